// File: rtl/load_return_unit.sv
// Load return unit: registers a load request in the memory stage, returns the
// aligned and extended load result exactly one cycle later, and serves the
// memory-mapped UART status/data and cycle/instruction counters.
module load_return_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] dmem_dout,
  input  logic [WIDTH-1:0] bios_dout,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  input  logic             uart_tx_ready,
  input  logic             instr_retired,
  input  logic             ctr_rst_we,
  output logic             uart_rx_ready,
  output logic [WIDTH-1:0] load_data,
  output logic             load_data_valid
);

  typedef enum logic [1:0] {
    RegionNone = 2'd0,
    RegionDmem = 2'd1,
    RegionBios = 2'd2,
    RegionMmio = 2'd3
  } region_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [WIDTH-1:0] UartRxAddr = WIDTH'(32'h8000_0004);

  // Registered request state for the load returning next cycle
  logic             valid_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  region_e          region_q;
  logic [WIDTH-1:0] mmio_q;

  region_e          region_d;
  logic [WIDTH-1:0] mmio_d;

  // Free-running counters visible through MMIO
  logic [31:0] cycleCnt_q, cycleCnt_d;
  logic [31:0] instrCnt_q, instrCnt_d;

  // Byte/half extraction intermediates
  logic [WIDTH-1:0] srcWord;
  logic [7:0]       byteSel;
  logic [15:0]      halfSel;

  // Only funct3 of the instruction matters here
  logic unusedInstrBits;
  assign unusedInstrBits = ^{instr[WIDTH-1:15], instr[11:0]};

  // Decode the target region from the top address nibble
  always_comb begin
    region_d = RegionNone;
    case (addr[31:28])
      4'b0001, 4'b0011: region_d = RegionDmem;
      4'b0100:          region_d = RegionBios;
      4'b1000:          region_d = RegionMmio;
      default:          region_d = RegionNone;
    endcase
  end

  // MMIO read value is sampled in the request cycle so counters return their pre-edge value
  always_comb begin
    mmio_d = '0;
    case (addr[7:0])
      8'h00:   mmio_d = WIDTH'({uart_rx_valid, uart_tx_ready});
      8'h04:   mmio_d = WIDTH'(uart_rx_data);
      8'h10:   mmio_d = WIDTH'(cycleCnt_q);
      8'h14:   mmio_d = WIDTH'(instrCnt_q);
      default: mmio_d = '0;
    endcase
  end

  // Pop the UART receive byte only when a load actually reads the data register
  always_comb begin
    uart_rx_ready = 1'b0;
    if (!rst && load_valid && (addr == UartRxAddr) && uart_rx_valid) begin
      uart_rx_ready = 1'b1;
    end
  end

  // Counter next-state: a counter-reset store wins over the increment
  always_comb begin
    cycleCnt_d = cycleCnt_q + 32'd1;
    instrCnt_d = instrCnt_q;
    if (instr_retired) begin
      instrCnt_d = instrCnt_q + 32'd1;
    end
    if (ctr_rst_we) begin
      cycleCnt_d = '0;
      instrCnt_d = '0;
    end
  end

  // Capture the load request; reset discards any pending load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      region_q <= RegionNone;
      mmio_q   <= '0;
    end else begin
      valid_q <= load_valid;
      if (load_valid) begin
        funct3_q <= instr[14:12];
        off_q    <= addr[1:0];
        region_q <= region_d;
        mmio_q   <= mmio_d;
      end
    end
  end

  // Cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt_q <= '0;
      instrCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_d;
      instrCnt_q <= instrCnt_d;
    end
  end

  // Select the source word and slice out the addressed byte and half
  always_comb begin
    srcWord = '0;
    case (region_q)
      RegionDmem: srcWord = dmem_dout;
      RegionBios: srcWord = bios_dout;
      RegionMmio: srcWord = mmio_q;
      default:    srcWord = '0;
    endcase
    byteSel = srcWord[{off_q, 3'b000} +: 8];
    halfSel = srcWord[{off_q[1], 4'b0000} +: 16];
  end

  // Extend the selected data and present it only in the return cycle
  always_comb begin
    load_data       = '0;
    load_data_valid = 1'b0;
    if (valid_q && !rst) begin
      load_data_valid = 1'b1;
      case (funct3_q)
        F3Lb:    load_data = {{(WIDTH-8){byteSel[7]}}, byteSel};
        F3Lbu:   load_data = {{(WIDTH-8){1'b0}}, byteSel};
        F3Lh:    load_data = {{(WIDTH-16){halfSel[15]}}, halfSel};
        F3Lhu:   load_data = {{(WIDTH-16){1'b0}}, halfSel};
        F3Lw:    load_data = srcWord;
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_return_unit.sv
// Directed bench for load_return_unit: a table of single loads plus
// hand-written sequences for counters, reset and counter wrap.
module tb_load_return_unit;

  logic        clk;
  logic        rst;
  logic        loadValid;
  logic [31:0] instr;
  logic [31:0] addr;
  logic [31:0] dmemDout;
  logic [31:0] biosDout;
  logic [7:0]  uartRxData;
  logic        uartRxValid;
  logic        uartTxReady;
  logic        instrRetired;
  logic        ctrRstWe;
  logic        uartRxReady;
  logic [31:0] loadData;
  logic        loadDataValid;

  int checks = 0;
  int failures = 0;

  load_return_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid      (loadValid),
    .instr           (instr),
    .addr            (addr),
    .dmem_dout       (dmemDout),
    .bios_dout       (biosDout),
    .uart_rx_data    (uartRxData),
    .uart_rx_valid   (uartRxValid),
    .uart_tx_ready   (uartTxReady),
    .instr_retired   (instrRetired),
    .ctr_rst_we      (ctrRstWe),
    .uart_rx_ready   (uartRxReady),
    .load_data       (loadData),
    .load_data_valid (loadDataValid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] dmem;
    logic [31:0] bios;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        txReady;
    logic [31:0] expData;
    logic        expRxReady;
  } vec_t;

  vec_t vecs[17];

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Present a load request this cycle
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a);
    loadValid = 1'b1;
    instr     = {17'b0, f3, 5'b0, 7'b0000011};
    addr      = a;
  endtask

  // No load this cycle
  task automatic idle();
    loadValid = 1'b0;
    instr     = 32'h0;
    addr      = 32'h0;
  endtask

  initial begin
    // Vector table: funct3, addr, dmem, bios, rxData, rxValid, txReady, expected data, expected rx_ready
    vecs[0]  = '{3'b000, 32'h1000_0003, 32'h80FF_1234, 32'h0, 8'h00, 1'b0, 1'b0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{3'b100, 32'h1000_0003, 32'h80FF_1234, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0000_0080, 1'b0};
    vecs[2]  = '{3'b001, 32'h4000_0002, 32'h0, 32'h8001_ABCD, 8'h00, 1'b0, 1'b0, 32'hFFFF_8001, 1'b0};
    vecs[3]  = '{3'b101, 32'h4000_0000, 32'h0, 32'h8001_ABCD, 8'h00, 1'b0, 1'b0, 32'h0000_ABCD, 1'b0};
    vecs[4]  = '{3'b010, 32'h4000_0001, 32'h0, 32'h8001_ABCD, 8'h00, 1'b0, 1'b0, 32'h8001_ABCD, 1'b0};
    vecs[5]  = '{3'b010, 32'h8000_0004, 32'h0, 32'h0, 8'h5A, 1'b1, 1'b0, 32'h0000_005A, 1'b1};
    vecs[6]  = '{3'b010, 32'h8000_0004, 32'h0, 32'h0, 8'h5A, 1'b0, 1'b0, 32'h0000_005A, 1'b0};
    vecs[7]  = '{3'b010, 32'h2000_0000, 32'h1111_1111, 32'h2222_2222, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{3'b000, 32'h1000_0001, 32'h80FF_1234, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0000_0012, 1'b0};
    vecs[9]  = '{3'b001, 32'h1000_0003, 32'h80FF_1234, 32'h0, 8'h00, 1'b0, 1'b0, 32'hFFFF_80FF, 1'b0};
    vecs[10] = '{3'b011, 32'h1000_0000, 32'h80FF_1234, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{3'b010, 32'h8000_0000, 32'h0, 32'h0, 8'h00, 1'b1, 1'b1, 32'h0000_0003, 1'b0};
    vecs[12] = '{3'b010, 32'h8000_0008, 32'h0, 32'h0, 8'h77, 1'b1, 1'b1, 32'h0, 1'b0};
    vecs[13] = '{3'b010, 32'h3000_0000, 32'hDEAD_BEEF, 32'h0, 8'h00, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{3'b100, 32'h8000_0004, 32'h0, 32'h0, 8'hA5, 1'b1, 1'b0, 32'h0000_00A5, 1'b1};
    vecs[15] = '{3'b110, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[16] = '{3'b111, 32'h4000_0000, 32'h0, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0};

    rst = 1'b1;
    idle();
    dmemDout = 32'h0;
    biosDout = 32'h0;
    uartRxData = 8'h00;
    uartRxValid = 1'b0;
    uartTxReady = 1'b0;
    instrRetired = 1'b0;
    ctrRstWe = 1'b0;

    // Reset: a UART data read must be ignored and outputs held at zero
    @(negedge clk);
    applyStimulus(3'b010, 32'h8000_0004);
    uartRxValid = 1'b1;
    uartRxData = 8'h33;
    #1;
    checkOutput("reset_rx_ready", {31'b0, uartRxReady}, 32'h0);
    checkOutput("reset_valid", {31'b0, loadDataValid}, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("reset_ignores_load_valid", {31'b0, loadDataValid}, 32'h0);
    checkOutput("reset_data", loadData, 32'h0);

    // Counter sequence: counters start at 0 on the first edge after reset releases
    @(negedge clk);
    rst = 1'b0;
    idle();
    uartRxValid = 1'b0;
    instrRetired = 1'b1;
    repeat (3) @(negedge clk);
    instrRetired = 1'b0;
    repeat (7) @(negedge clk);
    applyStimulus(3'b010, 32'h8000_0010);
    @(negedge clk);
    applyStimulus(3'b010, 32'h8000_0014);
    #1;
    checkOutput("cycle_after_10", loadData, 32'd10);
    checkOutput("cycle_after_10_valid", {31'b0, loadDataValid}, 32'h1);
    @(negedge clk);
    idle();
    #1;
    checkOutput("instret_3", loadData, 32'd3);
    @(negedge clk);
    #1;
    checkOutput("valid_drops", {31'b0, loadDataValid}, 32'h0);

    // Counter clear in the same cycle as a read returns the old value
    @(negedge clk);
    ctrRstWe = 1'b1;
    applyStimulus(3'b010, 32'h8000_0010);
    @(negedge clk);
    ctrRstWe = 1'b0;
    idle();
    #1;
    checkOutput("ctr_clear_old_value", loadData, 32'd14);
    @(negedge clk);
    applyStimulus(3'b010, 32'h8000_0010);
    @(negedge clk);
    applyStimulus(3'b010, 32'h8000_0014);
    #1;
    checkOutput("cycle_after_clear", loadData, 32'd1);
    @(negedge clk);
    idle();
    #1;
    checkOutput("instret_after_clear", loadData, 32'd0);

    // Table of single loads
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      dmemDout = vecs[i].dmem;
      biosDout = vecs[i].bios;
      uartRxData = vecs[i].rxData;
      uartRxValid = vecs[i].rxValid;
      uartTxReady = vecs[i].txReady;
      applyStimulus(vecs[i].f3, vecs[i].a);
      #1;
      checkOutput($sformatf("vec%0d_rx_ready", i), {31'b0, uartRxReady}, {31'b0, vecs[i].expRxReady});
      @(negedge clk);
      idle();
      #1;
      checkOutput($sformatf("vec%0d_rx_ready_low", i), {31'b0, uartRxReady}, 32'h0);
      checkOutput($sformatf("vec%0d_data", i), loadData, vecs[i].expData);
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, loadDataValid}, 32'h1);
    end
    uartRxValid = 1'b0;
    uartTxReady = 1'b0;

    // Back-to-back loads from dmem then bios
    @(negedge clk);
    applyStimulus(3'b000, 32'h1000_0000);
    @(negedge clk);
    dmemDout = 32'h0000_00F0;
    applyStimulus(3'b101, 32'h4000_0002);
    #1;
    checkOutput("b2b_first", loadData, 32'hFFFF_FFF0);
    @(negedge clk);
    biosDout = 32'h9876_0000;
    idle();
    #1;
    checkOutput("b2b_second", loadData, 32'h0000_9876);
    checkOutput("b2b_second_valid", {31'b0, loadDataValid}, 32'h1);

    // Load with reset in the same cycle never returns
    @(negedge clk);
    dmemDout = 32'h1234_5678;
    applyStimulus(3'b010, 32'h1000_0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    checkOutput("rst_discard_valid", {31'b0, loadDataValid}, 32'h0);
    checkOutput("rst_discard_data", loadData, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_discard_stays", {31'b0, loadDataValid}, 32'h0);

    // Reset during the return cycle hides and drops the result
    @(negedge clk);
    applyStimulus(3'b010, 32'h1000_0000);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    checkOutput("rst_return_valid", {31'b0, loadDataValid}, 32'h0);
    checkOutput("rst_return_data", loadData, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_return_gone", {31'b0, loadDataValid}, 32'h0);

    // Cycle counter wrap from all-ones to zero
    @(negedge clk);
    force dut.cycleCnt_q = 32'hFFFF_FFFF;
    release dut.cycleCnt_q;
    applyStimulus(3'b010, 32'h8000_0010);
    @(negedge clk);
    applyStimulus(3'b010, 32'h8000_0010);
    #1;
    checkOutput("wrap_before", loadData, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    #1;
    checkOutput("wrap_after", loadData, 32'h0000_0000);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
